// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32I data-memory access stage with alignment checks and load extension
module mem_access_unit #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_load,
  input  logic [2:0]             req_funct3,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  output logic [31:0]            resp_rdata,
  output logic                   resp_fault,
  output logic [31:0]            dmem_addr,
  output logic                   dmem_read,
  output logic                   dmem_write,
  output logic [3:0]             dmem_mbe,
  output logic [31:0]            dmem_wdata,
  input  logic [31:0]            dmem_rdata,
  input  logic                   dmem_resp,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [STALL_CNT_W-1:0] STALL_ONE = 1;

  state_t      state;
  logic        load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic        req_legal;
  logic [3:0]  req_mbe;
  logic [1:0]  req_off;
  logic [31:0] req_wdata_sh;
  logic [31:0] load_lane;
  logic [31:0] load_ext;

  assign req_off      = req_addr[1:0];
  assign req_wdata_sh = req_wdata << {req_off, 3'b000};

  // Decode legality and byte enables straight from the incoming request
  always_comb begin
    req_legal = 1'b0;
    req_mbe   = 4'b0000;
    case (req_funct3)
      3'b000: begin
        req_legal = 1'b1;
        req_mbe   = 4'b0001 << req_off;
      end
      3'b001: begin
        req_legal = ~req_addr[0];
        req_mbe   = 4'b0011 << req_off;
      end
      3'b010: begin
        req_legal = (req_off == 2'b00);
        req_mbe   = 4'b1111;
      end
      3'b100: begin
        req_legal = req_load;
        req_mbe   = 4'b0001 << req_off;
      end
      3'b101: begin
        req_legal = req_load & ~req_addr[0];
        req_mbe   = 4'b0011 << req_off;
      end
      default: begin
        req_legal = 1'b0;
        req_mbe   = 4'b0000;
      end
    endcase
  end

  assign load_lane = dmem_rdata >> {off_q, 3'b000};

  // Extend the selected lane of the returned word according to the latched funct3
  always_comb begin
    load_ext = load_lane;
    case (funct3_q)
      3'b000:  load_ext = {{24{load_lane[7]}}, load_lane[7:0]};
      3'b100:  load_ext = {24'h000000, load_lane[7:0]};
      3'b001:  load_ext = {{16{load_lane[15]}}, load_lane[15:0]};
      3'b101:  load_ext = {16'h0000, load_lane[15:0]};
      default: load_ext = load_lane;
    endcase
  end

  // Request/response FSM; every output is a register so strobes are glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      load_q       <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'h0;
      resp_fault   <= 1'b0;
      dmem_addr    <= 32'h0;
      dmem_read    <= 1'b0;
      dmem_write   <= 1'b0;
      dmem_mbe     <= 4'b0000;
      dmem_wdata   <= 32'h0;
      stall_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            load_q    <= req_load;
            funct3_q  <= req_funct3;
            off_q     <= req_off;
            req_ready <= 1'b0;
            if (req_legal) begin
              state      <= ACCESS;
              dmem_addr  <= {req_addr[31:2], 2'b00};
              dmem_mbe   <= req_mbe;
              dmem_wdata <= req_wdata_sh;
              dmem_read  <= req_load;
              dmem_write <= ~req_load;
            end else begin
              // Illegal accesses never reach memory and answer on the next cycle
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= 32'h0;
            end
          end
        end
        ACCESS: begin
          if (dmem_resp) begin
            state      <= DONE;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= load_q ? load_ext : 32'h0;
          end else if (stall_cycles != '1) begin
            stall_cycles <= stall_cycles + STALL_ONE;
          end
        end
        DONE: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          dmem_read  <= 1'b0;
          dmem_write <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int SW = 5;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_load;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_fault;
  logic [31:0]   dmem_addr;
  logic          dmem_read;
  logic          dmem_write;
  logic [3:0]    dmem_mbe;
  logic [31:0]   dmem_wdata;
  logic [31:0]   dmem_rdata;
  logic          dmem_resp;
  logic [SW-1:0] stall_cycles;

  int nvec = 0;
  int nerr = 0;
  int exp_stall = 0;

  mem_access_unit #(.STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .dmem_addr(dmem_addr), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_mbe(dmem_mbe), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready_before;
    logic        ready_after;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mbe;
    logic [31:0] wdata;
    logic        steady;
    logic        got;
    logic [31:0] rdata;
    logic        fault;
    logic        strobe_at_resp;
    int          lat;
    logic        pulse_low;
    logic        ready_end;
    int          stall;
  } obs_t;

  // ---- reference model ----
  function automatic bit m_legal(input bit ld, input int f3, input int unsigned a);
    int off = a % 4;
    case (f3)
      0: return 1;
      1: return (off % 2) == 0;
      2: return off == 0;
      4: return ld;
      5: return ld && (off % 2) == 0;
      default: return 0;
    endcase
  endfunction

  function automatic int m_size(input int f3);
    return (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_mbe(input int f3, input int unsigned a);
    int sz = m_size(f3);
    int off = (sz == 4) ? 0 : a % 4;
    int unsigned v = ((1 << sz) - 1) << off;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_lanemask(input logic [3:0] mbe);
    logic [31:0] m = 0;
    for (int k = 0; k < 4; k++) if (mbe[k]) m = m | (32'hFF << (8 * k));
    return m;
  endfunction

  function automatic logic [31:0] m_load(input int f3, input int unsigned a, input logic [31:0] w);
    int off = a % 4;
    longint unsigned lane = w >> (8 * off);
    longint v;
    case (f3)
      0: begin v = lane % 256;   if (v >= 128)   v = v - 256;   end
      4: v = lane % 256;
      1: begin v = lane % 65536; if (v >= 32768) v = v - 65536; end
      5: v = lane % 65536;
      default: v = lane;
    endcase
    return v[31:0];
  endfunction

  function automatic void stall_add(input int n);
    exp_stall = exp_stall + n;
    if (exp_stall > SMAX) exp_stall = SMAX;
  endfunction

  // ---- driver: issues one request, plays memory, collects observations ----
  task automatic do_access(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd_word,
                           input int wait_n, output obs_t o);
    int cyc;
    o.ready_before = req_ready;
    req_valid = 1'b1; req_load = ld; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_load = $urandom; req_funct3 = $urandom; req_addr = $urandom; req_wdata = $urandom;
    o.rd = dmem_read; o.wr = dmem_write; o.addr = dmem_addr; o.mbe = dmem_mbe;
    o.wdata = dmem_wdata; o.ready_after = req_ready;
    o.steady = 1'b1;
    cyc = 1;
    for (int i = 0; i < wait_n + 8 && !resp_valid; i++) begin
      dmem_resp  = (i == wait_n);
      dmem_rdata = (i == wait_n) ? rd_word : $urandom;
      req_valid  = $urandom_range(0, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      dmem_resp = 1'b0;
      cyc++;
      if (!resp_valid && (dmem_read !== o.rd || dmem_write !== o.wr || dmem_addr !== o.addr ||
                          dmem_mbe !== o.mbe || dmem_wdata !== o.wdata))
        o.steady = 1'b0;
    end
    o.got = resp_valid;
    o.rdata = resp_rdata;
    o.fault = resp_fault;
    o.strobe_at_resp = dmem_read | dmem_write;
    o.lat = cyc;
    dmem_resp = $urandom_range(0, 1);
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    o.pulse_low = ~resp_valid;
    o.ready_end = req_ready;
    o.stall = int'(stall_cycles);
  endtask

  // ---- tests ----
  task automatic test_reset;
    rst = 1'b1;
    req_valid = 0; req_load = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    dmem_rdata = 0; dmem_resp = 0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if ({req_ready, resp_valid, resp_fault, dmem_read, dmem_write} !== 5'b10000 ||
        resp_rdata !== 0 || dmem_addr !== 0 || dmem_mbe !== 0 || dmem_wdata !== 0 ||
        stall_cycles !== 0) begin
      nerr++;
      $display("FAIL reset_state: ready=%b rv=%b flt=%b rd=%b wr=%b rdata=%h addr=%h mbe=%b wd=%h stall=%0d, required ready=1 rest 0",
               req_ready, resp_valid, resp_fault, dmem_read, dmem_write, resp_rdata, dmem_addr,
               dmem_mbe, dmem_wdata, stall_cycles);
    end
    rst = 1'b0;
    exp_stall = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_plan_loads;
    obs_t o;
    logic [2:0]  f3s   [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] addrs [5] = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] words [5] = '{32'hDEADBEEF, 32'h80FF0011, 32'h80FF0011, 32'h8001ABCD, 32'h8001ABCD};
    logic [31:0] exps  [5] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
    logic [3:0]  mbes  [5] = '{4'b1111, 4'b1000, 4'b1000, 4'b1100, 4'b1100};
    for (int k = 0; k < 5; k++) begin
      int w = (k == 0) ? 3 : k % 2;
      do_access(1'b1, f3s[k], addrs[k], 32'h0, words[k], w, o);
      stall_add(w);
      nvec++;
      if (o.rd !== 1'b1 || o.wr !== 1'b0 || o.addr !== (addrs[k] & 32'hFFFFFFFC) || o.mbe !== mbes[k]) begin
        nerr++;
        $display("FAIL plan_load_strobe[%0d]: rd=%b wr=%b addr=%h mbe=%b, required 1 0 %h %b",
                 k, o.rd, o.wr, o.addr, o.mbe, addrs[k] & 32'hFFFFFFFC, mbes[k]);
      end
      nvec++;
      if (!o.got || o.rdata !== exps[k] || o.fault !== 1'b0 || o.lat != w + 2 || !o.pulse_low) begin
        nerr++;
        $display("FAIL plan_load_resp[%0d]: got=%b rdata=%h fault=%b lat=%0d pulse_low=%b, required 1 %h 0 %0d 1",
                 k, o.got, o.rdata, o.fault, o.lat, o.pulse_low, exps[k], w + 2);
      end
      nvec++;
      if (o.stall != exp_stall) begin
        nerr++;
        $display("FAIL plan_load_stall[%0d]: stall=%0d, required %0d", k, o.stall, exp_stall);
      end
    end
  endtask

  task automatic test_store;
    obs_t o;
    do_access(1'b0, 3'b000, 32'h201, 32'h000000A5, 32'h0, 1, o);
    stall_add(1);
    nvec++;
    if (o.wr !== 1'b1 || o.rd !== 1'b0 || o.addr !== 32'h200 || o.mbe !== 4'b0010 ||
        o.wdata[15:8] !== 8'hA5 || !o.steady) begin
      nerr++;
      $display("FAIL store_sb: wr=%b rd=%b addr=%h mbe=%b lane=%h steady=%b, required 1 0 00000200 0010 a5 1",
               o.wr, o.rd, o.addr, o.mbe, o.wdata[15:8], o.steady);
    end
    nvec++;
    if (!o.got || o.fault !== 1'b0 || o.strobe_at_resp !== 1'b0 || !o.ready_end) begin
      nerr++;
      $display("FAIL store_resp: got=%b fault=%b strobe=%b ready=%b, required 1 0 0 1",
               o.got, o.fault, o.strobe_at_resp, o.ready_end);
    end
  endtask

  task automatic test_fault;
    obs_t o;
    logic        lds [2] = '{1'b0, 1'b1};
    logic [2:0]  f3s [2] = '{3'b001, 3'b011};
    logic [31:0] as  [2] = '{32'h201, 32'h100};
    for (int k = 0; k < 2; k++) begin
      do_access(lds[k], f3s[k], as[k], 32'hFFFF, 32'h12345678, 0, o);
      nvec++;
      if (o.rd !== 1'b0 || o.wr !== 1'b0 || !o.got || o.fault !== 1'b1 || o.rdata !== 32'h0 ||
          o.lat != 1 || !o.pulse_low || !o.ready_end || o.ready_after !== 1'b0) begin
        nerr++;
        $display("FAIL fault[%0d]: rd=%b wr=%b got=%b fault=%b rdata=%h lat=%0d pulse_low=%b ready=%b/%b, required 0 0 1 1 0 1 1 0/1",
                 k, o.rd, o.wr, o.got, o.fault, o.rdata, o.lat, o.pulse_low, o.ready_after, o.ready_end);
      end
      nvec++;
      if (o.stall != exp_stall) begin
        nerr++;
        $display("FAIL fault_stall[%0d]: stall=%0d, required %0d", k, o.stall, exp_stall);
      end
    end
  endtask

  task automatic test_reset_mid_access;
    obs_t o;
    logic saw_resp = 1'b0;
    req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    nvec++;
    if (dmem_read !== 1'b1 || stall_cycles === 0) begin
      nerr++;
      $display("FAIL rst_pre: dmem_read=%b stall=%0d, required 1 and nonzero", dmem_read, stall_cycles);
    end
    rst = 1'b1;
    #1;
    nvec++;
    if (dmem_read !== 1'b0 || req_ready !== 1'b1 || stall_cycles !== 0) begin
      nerr++;
      $display("FAIL rst_async: dmem_read=%b req_ready=%b stall=%0d, required 0 1 0",
               dmem_read, req_ready, stall_cycles);
    end
    dmem_resp = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    repeat (2) begin
      @(posedge clk); #1;
      if (resp_valid) saw_resp = 1'b1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    if (resp_valid) saw_resp = 1'b1;
    dmem_resp = 1'b0;
    @(posedge clk); #1;
    if (resp_valid) saw_resp = 1'b1;
    exp_stall = 0;
    nvec++;
    if (saw_resp) begin
      nerr++;
      $display("FAIL rst_no_resp: resp_valid seen=1, required 0");
    end
    do_access(1'b1, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 2, o);
    stall_add(2);
    nvec++;
    if (!o.got || o.rdata !== 32'hCAFEF00D || o.fault !== 1'b0 || o.stall != exp_stall) begin
      nerr++;
      $display("FAIL rst_recover: got=%b rdata=%h fault=%b stall=%0d, required 1 cafef00d 0 %0d",
               o.got, o.rdata, o.fault, o.stall, exp_stall);
    end
  endtask

  task automatic test_random;
    obs_t o;
    for (int n = 0; n < 60; n++) begin
      logic        ld = $urandom_range(0, 1);
      logic [2:0]  f3 = $urandom_range(0, 7);
      logic [31:0] a  = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] rw = $urandom;
      int          w  = $urandom_range(0, 3);
      bit          legal = m_legal(ld, int'(f3), a);
      logic [3:0]  em = m_mbe(int'(f3), a);
      logic [31:0] lm = m_lanemask(em);
      logic [31:0] ew = wd << (8 * (a % 4));
      do_access(ld, f3, a, wd, rw, w, o);
      if (legal) stall_add(w);
      nvec++;
      if (legal) begin
        if (o.rd !== ld || o.wr !== !ld || o.addr !== {a[31:2], 2'b00} || o.mbe !== em ||
            (!ld && ((o.wdata & lm) !== (ew & lm))) || !o.steady || !o.got || o.fault !== 1'b0 ||
            (ld && o.rdata !== m_load(int'(f3), a, rw)) || o.lat != w + 2 || !o.pulse_low ||
            !o.ready_before || o.ready_after !== 1'b0 || !o.ready_end || o.stall != exp_stall) begin
          nerr++;
          $display("FAIL random_legal[%0d]: ld=%b f3=%0d a=%h rd=%b wr=%b addr=%h mbe=%b wd=%h rdata=%h fault=%b lat=%0d steady=%b stall=%0d, required mbe=%b wd=%h rdata=%h lat=%0d stall=%0d",
                   n, ld, f3, a, o.rd, o.wr, o.addr, o.mbe, o.wdata & lm, o.rdata, o.fault, o.lat,
                   o.steady, o.stall, em, ew & lm, m_load(int'(f3), a, rw), w + 2, exp_stall);
        end
      end else begin
        if (o.rd !== 1'b0 || o.wr !== 1'b0 || !o.got || o.fault !== 1'b1 || o.rdata !== 32'h0 ||
            o.lat != 1 || !o.pulse_low || !o.ready_end || o.stall != exp_stall) begin
          nerr++;
          $display("FAIL random_fault[%0d]: ld=%b f3=%0d a=%h rd=%b wr=%b fault=%b rdata=%h lat=%0d stall=%0d, required 0 0 1 0 1 %0d",
                   n, ld, f3, a, o.rd, o.wr, o.fault, o.rdata, o.lat, o.stall, exp_stall);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    obs_t o;
    logic bad = 1'b0;
    dmem_resp = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (resp_valid || dmem_read || dmem_write || int'(stall_cycles) != exp_stall) bad = 1'b1;
    end
    dmem_resp = 1'b0;
    nvec++;
    if (bad) begin
      nerr++;
      $display("FAIL idle_resp_ignored: rv=%b rd=%b wr=%b stall=%0d, required 0 0 0 %0d",
               resp_valid, dmem_read, dmem_write, stall_cycles, exp_stall);
    end
    do_access(1'b0, 3'b010, 32'h300, 32'h11223344, 32'h0, 0, o);
    do_access(1'b1, 3'b101, 32'h302, 32'h0, 32'hF00D1234, 0, o);
    nvec++;
    if (!o.ready_before || !o.got || o.rdata !== 32'h0000F00D || o.lat != 2) begin
      nerr++;
      $display("FAIL back_to_back: ready=%b got=%b rdata=%h lat=%0d, required 1 1 0000f00d 2",
               o.ready_before, o.got, o.rdata, o.lat);
    end
  endtask

  task automatic test_stall_saturation;
    obs_t o;
    do_access(1'b1, 3'b000, 32'h7, 32'h0, 32'h00000000, SMAX + 4, o);
    stall_add(SMAX + 4);
    nvec++;
    if (o.stall != SMAX || !o.got || o.lat != SMAX + 6) begin
      nerr++;
      $display("FAIL stall_saturate: stall=%0d got=%b lat=%0d, required %0d 1 %0d",
               o.stall, o.got, o.lat, SMAX, SMAX + 6);
    end
  endtask

  initial begin
    test_reset();
    test_plan_loads();
    test_store();
    test_fault();
    test_reset_mid_access();
    test_random();
    test_back_to_back();
    test_stall_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage for the RV32I datapath; sits between the MEM stage control and the data-memory port.
- Accepts one load/store request at a time, issues a word-aligned access with byte enables, and waits for dmem_resp.
- Returns the load data already shifted and sign/zero-extended per funct3, so the regfilemux lb/lbu/lh/lhu/lw inputs all become this one value.
- Detects misaligned or illegal accesses and reports them without touching memory.

Parameters:
- STALL_CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_load  in  1  1 = load, 0 = store
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  byte address (ALU output)
- req_wdata  in  32  store data (rs2), unshifted
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  aligned, extended load data
- resp_fault  out  1  misaligned/illegal access, qualified by resp_valid
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_read  out  1  memory read strobe
- dmem_write  out  1  memory write strobe
- dmem_mbe  out  4  byte enables
- dmem_wdata  out  32  lane-shifted store data
- dmem_rdata  in  32  memory read data
- dmem_resp  in  1  memory access complete
- stall_cycles  out  STALL_CNT_W  saturating count of ACCESS cycles spent waiting

Behaviour:
- Reset (async, active-high): state = IDLE; all outputs 0 except req_ready = 1; stall_cycles = 0.
- States and transitions:
  - IDLE: req_ready = 1. On req_valid, latch load, funct3, addr and wdata.
    - Legal access: go to ACCESS.
    - Illegal access: go to DONE with fault = 1.
  - ACCESS: dmem_read = load and dmem_write = !load, both held steady with addr, mbe and wdata until the cycle dmem_resp = 1. In that cycle, capture dmem_rdata (loads) and go to DONE. stall_cycles increments each ACCESS cycle with dmem_resp = 0, saturating at all-ones.
  - DONE: resp_valid = 1 for exactly one cycle, resp_rdata/resp_fault valid, then go to IDLE. req_ready = 0 in ACCESS and DONE.
- Latency: request accepted in cycle N → ACCESS in N+1 → resp_valid no earlier than N+2 (when dmem_resp arrives in N+1). A fault responds at N+1.
- Legality:
  - Loads legal for funct3 000/001/010/100/101; stores legal for 000/001/010.
  - Half accesses need addr[0] = 0; word accesses need addr[1:0] = 0.
  - Anything else sets fault; dmem_read/write are never asserted and resp_rdata = 0.
- Byte enables: off = addr[1:0].
  - Byte: mbe = 0001 << off.
  - Half: mbe = 0011 << off.
  - Word: mbe = 1111.
  - Loads drive mbe the same way (informational).
- Store data: dmem_wdata = wdata << (8*off); unused lanes are don't-care.
- Load data: lane = dmem_rdata >> (8*off).
  - lb: sign-extend lane[7:0]; lbu: zero-extend lane[7:0].
  - lh: sign-extend lane[15:0]; lhu: zero-extend lane[15:0].
  - lw: full word.
- Request inputs are ignored outside IDLE; the latched copies drive all outputs.
- dmem_resp outside ACCESS is ignored.
- Reset mid-ACCESS aborts immediately: strobes drop and no resp_valid is produced.

Test Plan:
- Load lw at 0x00000100, dmem_resp after 3 wait cycles, dmem_rdata = 0xDEADBEEF → dmem_addr = 0x100, mbe = 1111, resp_rdata = 0xDEADBEEF, stall_cycles = 3, resp_valid for 1 cycle.
- Load lb at 0x103, dmem_rdata = 0x80FF0011 → resp_rdata = 0xFFFFFF80. Same access as lbu → resp_rdata = 0x00000080.
- Load lh at 0x102, dmem_rdata = 0x8001ABCD → resp_rdata = 0xFFFF8001. Same access as lhu → resp_rdata = 0x00008001.
- Store sb at 0x201, wdata = 0x000000A5 → dmem_write = 1, dmem_addr = 0x200, mbe = 0010, dmem_wdata[15:8] = 0xA5.
- Store sh at 0x201 → no dmem_read/write ever asserted, resp_valid one cycle after accept with resp_fault = 1. Load with funct3 = 011 → same fault response.
- rst asserted during ACCESS → dmem_read drops asynchronously, req_ready = 1, no resp_valid. The next lw completes normally.
